// File: rtl/gestore_reset_rete_pkg.sv
// Shared types for the staged reset sequencer: FSM states, reset causes and
// the saturating trigger-counter helper.
package pkg_gestore_reset;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } stato_t;

  typedef enum logic [1:0] {
    CAUSA_ACCENSIONE = 2'd0,
    CAUSA_LOCK       = 2'd1,
    CAUSA_CMD        = 2'd2,
    CAUSA_WD         = 2'd3
  } causa_t;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/gestore_reset_rete_watchdog.sv
// Activity watchdog: counts RUN cycles since the last kick and emits an expiry
// strobe (combinational, for the sequencer) plus a registered one-cycle flag.
module gestore_reset_watchdog #(
  parameter int WD_WIDTH = 24
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                run_i,
  input  logic                en_i,
  input  logic                kick_i,
  input  logic [WD_WIDTH-1:0] timeout_i,
  output logic                expire_o,
  output logic                flag_o
);

  logic [WD_WIDTH-1:0] cnt_q, cnt_d;
  logic                flag_q, flag_d;
  logic                attivo;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  // A kick in the expiry cycle suppresses the expiry.
  always_comb begin
    attivo   = run_i && en_i && (timeout_i != '0);
    expire_o = attivo && !kick_i && (cnt_q == timeout_i - 1'b1);
    flag_d   = expire_o;
    if (!attivo || kick_i || expire_o) cnt_d = '0;
    else                               cnt_d = cnt_q + 1'b1;
  end

  assign flag_o = flag_q;

endmodule

// File: rtl/gestore_reset_rete.sv
// Staged reset sequencer: merges lock loss, host command and watchdog triggers,
// holds all stages, then releases them in order. Watchdog built only when
// GESTORE_RESET_WATCHDOG_EN is defined.
module gestore_reset_rete
  import pkg_gestore_reset::*;
#(
  parameter int N_STAGE   = 3,
  parameter int HOLD_LEN  = 8,
  parameter int STAGE_GAP = 1,
  parameter int WD_WIDTH  = 24
) (
  input  logic                clk,
  input  logic                i_rst_g,
  input  logic                i_locked,
  input  logic                i_rst_cmd,
  input  logic                i_wd_en,
  input  logic                i_wd_kick,
  input  logic [WD_WIDTH-1:0] i_wd_timeout,
  output logic [N_STAGE-1:0]  od_rst,
  output logic                od_busy,
  output logic                od_wd_flag,
  output logic [1:0]          od_cause,
  output logic [CNT_W-1:0]    od_rst_count
);

  localparam int REL_LAST = (N_STAGE - 1) * STAGE_GAP;
  localparam int HOLD_W   = $clog2(HOLD_LEN + 1);
  localparam int REL_W    = $clog2(REL_LAST + 2);
  localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(HOLD_LEN - 1);
  localparam logic [REL_W-1:0]  REL_END  = REL_W'(REL_LAST);

  logic               lock_meta_q, lock_s_q;
  stato_t             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [REL_W-1:0]   rel_q, rel_d;
  logic [N_STAGE-1:0] rst_q, rst_d;
  causa_t             cause_q, cause_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wd_expire;

`ifdef GESTORE_RESET_WATCHDOG_EN
  logic run_w;
  assign run_w = (state_q == RUN);

  gestore_reset_watchdog #(.WD_WIDTH(WD_WIDTH)) u_wd (
    .clk_i     (clk),
    .rst_i     (i_rst_g),
    .run_i     (run_w),
    .en_i      (i_wd_en),
    .kick_i    (i_wd_kick),
    .timeout_i (i_wd_timeout),
    .expire_o  (wd_expire),
    .flag_o    (od_wd_flag)
  );
`else
  logic unused_wd;
  assign unused_wd  = ^{i_wd_en, i_wd_kick, i_wd_timeout};
  assign wd_expire  = 1'b0;
  assign od_wd_flag = 1'b0;
`endif

  always_ff @(posedge clk or posedge i_rst_g) begin
    if (i_rst_g) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= WAIT_LOCK;
      hold_q      <= '0;
      rel_q       <= '0;
      rst_q       <= '1;
      cause_q     <= CAUSA_ACCENSIONE;
      cnt_q       <= '0;
    end else begin
      lock_meta_q <= i_locked;
      lock_s_q    <= lock_meta_q;
      state_q     <= state_d;
      hold_q      <= hold_d;
      rel_q       <= rel_d;
      rst_q       <= rst_d;
      cause_q     <= cause_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rel_d   = rel_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      WAIT_LOCK: if (lock_s_q) begin
        state_d = HOLD;
        hold_d  = '0;
      end
      HOLD: if (hold_q == HOLD_END) begin
        state_d = RELEASE;
        rel_d   = '0;
      end else begin
        hold_d = hold_q + 1'b1;
      end
      RELEASE: if (rel_q == REL_END) state_d = RUN;
               else                  rel_d   = rel_q + 1'b1;
      RUN: ;
    endcase
    // Triggers override the normal progression; lock loss has top priority.
    if (state_q != WAIT_LOCK) begin
      if (!lock_s_q) begin
        state_d = WAIT_LOCK;
        cause_d = CAUSA_LOCK;
        cnt_d   = sat_inc(cnt_q);
      end else if (i_rst_cmd) begin
        state_d = HOLD;
        hold_d  = '0;
        cause_d = CAUSA_CMD;
        cnt_d   = sat_inc(cnt_q);
      end else if (wd_expire) begin
        state_d = HOLD;
        hold_d  = '0;
        cause_d = CAUSA_WD;
        cnt_d   = sat_inc(cnt_q);
      end
    end
    // Reset outputs are registered from the next state so they never glitch.
    rst_d = '1;
    if (state_d == RUN) begin
      rst_d = '0;
    end else if (state_d == RELEASE) begin
      for (int k = 0; k < N_STAGE; k++) rst_d[k] = (rel_d < REL_W'(k * STAGE_GAP));
    end
  end

  always_comb begin
    od_rst       = rst_q;
    od_busy      = (state_q != RUN);
    od_cause     = cause_q;
    od_rst_count = cnt_q;
  end

endmodule

// File: doc/gestore_reset_rete.md
Name: gestore_reset_rete

Overview:
- Parametrised successor to the fixed 3-bit reset shift chains that sit beside the CNN core.
- Sequences N staged active-high logic resets from one clock domain, releasing them in order with a configurable hold and gap.
- Merges reset sources (configuration lock, host reset command, internal watchdog) and records why each reset happened.
- Sits between the global reset generator and the ethernet payload handler / neural network core.

Parameters:
N_STAGE, 3, number of staged reset outputs (1..8)
HOLD_LEN, 8, cycles all stages stay asserted after every trigger (>=1)
STAGE_GAP, 1, cycles between release of consecutive stages (>=1)
WD_WIDTH, 24, watchdog counter width

Ports:
clk  in  1  system clock (~200 MHz)
i_rst_g  in  1  asynchronous active-high reset
i_locked  in  1  config-complete/lock level, asynchronous to clk
i_rst_cmd  in  1  single-cycle host reset command
i_wd_en  in  1  watchdog enable level
i_wd_kick  in  1  single-cycle activity strobe, clears watchdog
i_wd_timeout  in  WD_WIDTH  watchdog limit in cycles; 0 = disabled
od_rst  out  N_STAGE  staged resets; bit 0 releases first, bit N_STAGE-1 last
od_busy  out  1  high in every state except RUN
od_wd_flag  out  1  one-cycle pulse on watchdog expiry
od_cause  out  2  last cause: 0 power/async, 1 lock loss, 2 command, 3 watchdog
od_rst_count  out  8  number of completed trigger events, saturating at 255

Behaviour:
- Reset is asynchronous and active-high; clock is clk. While i_rst_g: od_rst all ones, od_busy=1, od_wd_flag=0, od_cause=0, od_rst_count=0, state WAIT_LOCK, counters 0.
- i_locked is synchronised through 2 flops (lock_s) before any use.
- WAIT_LOCK: od_rst all ones; when lock_s=1 go to HOLD, hold counter=0.
- HOLD: od_rst all ones; count HOLD_LEN cycles, then go to RELEASE with stage counter=0.
- RELEASE: od_rst[k] clears at cycle k*STAGE_GAP after entry; bits clear one at a time, never reassert within RELEASE. After the last bit clears, enter RUN next cycle.
- Example: N_STAGE=3, STAGE_GAP=1 releases in three consecutive cycles, matching the existing chains.
- RUN: od_rst=0, od_busy=0; watchdog active.
- Triggers, checked in states HOLD, RELEASE and RUN:
  - lock_s=0: cause=1, go to WAIT_LOCK.
  - i_rst_cmd: cause=2, go to HOLD.
  - watchdog expiry (RUN only): cause=3, go to HOLD.
- On any trigger od_rst returns to all ones in the cycle after detection (registered), and od_rst_count increments once per trigger.
- Priority for simultaneous triggers: lock loss > command > watchdog. The power-up sequence does not increment od_rst_count.
- A trigger during HOLD restarts the hold count; during RELEASE it reasserts all bits and restarts from HOLD.
- Watchdog:
  - counter clears on i_wd_kick, on leaving RUN, or when i_wd_en=0 or i_wd_timeout=0.
  - Otherwise it increments each RUN cycle.
  - When counter == i_wd_timeout-1 and no kick that cycle: od_wd_flag pulses 1 cycle, counter clears. A kick in the expiry cycle wins (no expiry).
- od_cause updates only on a trigger and holds otherwise.

Optional Feature:
GESTORE_RESET_WATCHDOG_EN
- Defined: watchdog counter, expiry and cause 3 implemented as above.
- Undefined: no watchdog counter is generated, i_wd_* are ignored, od_wd_flag is tied 0, and cause 3 never occurs.

Decomposition:
- Shared package pkg_gestore_reset: state enum (WAIT_LOCK, HOLD, RELEASE, RUN), cause enum (CAUSA_ACCENSIONE, CAUSA_LOCK, CAUSA_CMD, CAUSA_WD), and the width constant of od_rst_count.
- One natural sub-module: gestore_reset_watchdog, containing the counter, kick/clear logic and expiry pulse; instantiated under the macro.
- The lock synchroniser stays inline.

Test Plan:
- Power-up, defaults: i_locked rises at cycle 10 -> od_rst=111 through hold; bits clear in order 110, 100, 000 over 3 consecutive cycles; od_busy falls; od_rst_count=0, od_cause=0.
- Command in RUN: i_rst_cmd one cycle -> od_rst=111 next cycle, held 8 cycles, staged release again; od_cause=2, od_rst_count=1.
- Watchdog (macro defined): i_wd_en=1, i_wd_timeout=100, no kicks -> od_wd_flag pulse exactly 100 cycles after RUN entry, od_cause=3; kick every 50 cycles -> no pulse.
- Lock loss mid-RELEASE (N_STAGE=4, STAGE_GAP=3): drop i_locked after bit 1 clears -> all bits reassert, state waits; regain lock -> full hold + release, od_cause=1.
- Simultaneous command and expiry in one cycle -> od_cause=2, od_rst_count increments by 1 only.
- Saturation: 260 commands -> od_rst_count stays 255.
- Macro undefined: timeout=5 -> od_wd_flag never asserts.
- Async reset mid-RUN -> od_rst=all ones immediately without a clock edge, od_rst_count=0.
